// File: rtl/cfg_ctrl_seq_pkg.sv
// Shared types and sizing helpers for the CC_CFG_CTRL load sequencer.
package cfg_ctrl_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STREAM,
        TAIL,
        RECFG,
        FIN
    } state_t;

    localparam int DEF_SETUP_CYC = 4;
    localparam int DEF_GAP_CYC   = 1;
    localparam int DEF_RECFG_CYC = 2;
    localparam int DEF_LEN_W     = 24;
    localparam int DEF_TIMEOUT   = 1024;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cfg_seq_cnt.sv
// Loadable down-counter with zero flag; load has priority and the count
// saturates at zero. Registered count, combinational zero flag, no backpressure.
module cfg_seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/cfg_ctrl_seq.sv
// Sequences a byte stream into the CC_CFG_CTRL primitive (EN/VALID/RECFG).
// All outputs registered: START -> EN in 1 cycle, handshake -> VALID in 1 cycle.
// Source is throttled via S_READY (pacing gap, byte budget); ABORT/timeout end the load.
module cfg_ctrl_seq
    import cfg_ctrl_seq_pkg::*;
#(
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC,
    parameter int RECFG_CYC = DEF_RECFG_CYC,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    input  logic             DO_RECFG,
    input  logic             ABORT,
    input  logic [7:0]       S_DATA,
    input  logic             S_VALID,
    output logic             S_READY,
    output logic [7:0]       CFG_DATA,
    output logic             CFG_EN,
    output logic             CFG_RECFG,
    output logic             CFG_VALID,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam int PH_MAX = (SETUP_CYC > RECFG_CYC) ? SETUP_CYC : RECFG_CYC;
    localparam int PH_W   = cnt_w(PH_MAX);
    localparam int GAP_W  = cnt_w(GAP_CYC);
    localparam int TO_W   = cnt_w(TIMEOUT - 1);

    state_t           state;
    state_t           state_nx;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] rem_nx;
    logic             recfg_req;
    logic             recfg_req_nx;

    logic             hs;
    logic             hs_eff;
    logic             starve;
    logic             start_ok;
    logic             err_nx;
    logic             gap_nx_zero;
    logic             s_ready_nx;

    logic             ph_load;
    logic [PH_W-1:0]  ph_val;
    logic [PH_W-1:0]  ph_cnt;
    logic             ph_zero;
    logic             gap_load;
    logic [GAP_W-1:0] gap_val;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_zero;
    logic             to_load;
    logic [TO_W-1:0]  to_cnt;
    logic             to_zero;
    logic             unused_cnt;

    assign hs     = S_VALID && S_READY;
    assign starve = (state == STREAM) && S_READY && !S_VALID;

    always_comb begin
        state_nx     = state;
        rem_nx       = remaining;
        recfg_req_nx = recfg_req;
        hs_eff       = 1'b0;
        start_ok     = 1'b0;
        err_nx       = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    if (LEN != '0) begin
                        state_nx     = SETUP;
                        rem_nx       = LEN;
                        recfg_req_nx = DO_RECFG;
                        start_ok     = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            SETUP: if (ph_zero) state_nx = STREAM;
            STREAM: begin
                if (hs) begin
                    hs_eff = 1'b1;
                    rem_nx = remaining - LEN_W'(1);
                end else if (starve && to_zero) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else if ((remaining == '0) && gap_zero) begin
                    state_nx = TAIL;
                end
            end
            TAIL:    if (ph_zero) state_nx = recfg_req ? RECFG : FIN;
            RECFG:   if (ph_zero) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // ABORT overrides everything, including a byte handshaken this cycle.
        if (ABORT && (state != IDLE)) begin
            state_nx = IDLE;
            hs_eff   = 1'b0;
            err_nx   = 1'b0;
        end
    end

    // One phase counter is shared by SETUP, TAIL and RECFG; reload on each entry.
    assign ph_load  = (state_nx != state) && (state_nx inside {SETUP, TAIL, RECFG});
    assign ph_val   = (state_nx == RECFG) ? PH_W'(RECFG_CYC - 1) : PH_W'(SETUP_CYC - 1);
    assign gap_load = hs_eff || start_ok;
    assign gap_val  = hs_eff ? GAP_W'(GAP_CYC) : '0;
    assign to_load  = hs_eff || ((state_nx == STREAM) && (state != STREAM));

    assign gap_nx_zero = hs_eff ? (GAP_CYC == 0) : (gap_cnt <= GAP_W'(1));
    assign s_ready_nx  = (state_nx == STREAM) && (rem_nx != '0) && gap_nx_zero;

    cfg_seq_cnt #(.W(PH_W)) u_phase_cnt (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (ph_load),
        .load_val (ph_val),
        .dec      (1'b1),
        .cnt      (ph_cnt),
        .zero     (ph_zero)
    );

    cfg_seq_cnt #(.W(GAP_W)) u_gap_cnt (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (gap_load),
        .load_val (gap_val),
        .dec      (1'b1),
        .cnt      (gap_cnt),
        .zero     (gap_zero)
    );

    cfg_seq_cnt #(.W(TO_W)) u_timeout_cnt (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (to_load),
        .load_val (TO_W'(TIMEOUT - 1)),
        .dec      (starve),
        .cnt      (to_cnt),
        .zero     (to_zero)
    );

    assign unused_cnt = ^{ph_cnt, to_cnt};

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            remaining <= '0;
            recfg_req <= 1'b0;
            S_READY   <= 1'b0;
            CFG_DATA  <= 8'h00;
            CFG_EN    <= 1'b0;
            CFG_RECFG <= 1'b0;
            CFG_VALID <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            state     <= state_nx;
            remaining <= rem_nx;
            recfg_req <= recfg_req_nx;
            S_READY   <= s_ready_nx;
            if (hs_eff) CFG_DATA <= S_DATA;
            CFG_EN    <= state_nx inside {SETUP, STREAM, TAIL, RECFG};
            CFG_RECFG <= (state_nx == RECFG);
            CFG_VALID <= hs_eff;
            BUSY      <= (state_nx != IDLE);
            DONE      <= (state_nx == FIN);
            ERR       <= err_nx;
        end
    end

endmodule

// File: tb/tb_cfg_ctrl_seq.sv
// Bench for cfg_ctrl_seq: timestamp-based reference model checked every cycle,
// directed scenarios with literal timing checks, then randomized traffic.
module tb_cfg_ctrl_seq;

    localparam int SETUP = 4;
    localparam int GAP   = 1;
    localparam int RCY   = 2;
    localparam int LW    = 24;
    localparam int TMO   = 16;

    logic          CLK = 1'b0;
    logic          RST_N, START, DO_RECFG, ABORT, S_VALID;
    logic [LW-1:0] LEN;
    logic [7:0]    S_DATA;
    logic          S_READY, CFG_EN, CFG_RECFG, CFG_VALID, BUSY, DONE, ERR;
    logic [7:0]    CFG_DATA;

    cfg_ctrl_seq #(
        .SETUP_CYC (SETUP),
        .GAP_CYC   (GAP),
        .RECFG_CYC (RCY),
        .LEN_W     (LW),
        .TIMEOUT   (TMO)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .LEN       (LEN),
        .DO_RECFG  (DO_RECFG),
        .ABORT     (ABORT),
        .S_DATA    (S_DATA),
        .S_VALID   (S_VALID),
        .S_READY   (S_READY),
        .CFG_DATA  (CFG_DATA),
        .CFG_EN    (CFG_EN),
        .CFG_RECFG (CFG_RECFG),
        .CFG_VALID (CFG_VALID),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: a load is described by its start time, bytes left,
    // last handshake time and (once the last byte is taken) the DONE time.
    int         mc      = 0;
    bit         act     = 1'b0;
    bit         armed   = 1'b0;
    int         t_st    = 0;
    int         n_left  = 0;
    int         t_hs    = -1000;
    int         done_at = -1;
    int         idle    = 0;
    bit         rr      = 1'b0;
    bit         e_vld   = 1'b0;
    bit         e_err   = 1'b0;
    logic [7:0] e_dat   = 8'h00;

    bit         auto_vld = 1'b0;
    logic [7:0] src_q[$];

    bit         r_en[0:39], r_vld[0:39], r_rc[0:39], r_done[0:39], r_err[0:39], r_busy[0:39];
    logic [7:0] r_dat[0:39];

    function automatic bit m_ready();
        return act && (mc >= t_st + 1 + SETUP) && (n_left > 0) && (mc >= t_hs + 1 + GAP);
    endfunction

    function automatic bit m_en();
        return act && ((done_at < 0) || (mc < done_at));
    endfunction

    function automatic bit m_recfg();
        return act && rr && (done_at >= 0) && (mc >= done_at - RCY) && (mc < done_at);
    endfunction

    function automatic bit m_done();
        return act && (mc == done_at);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, mc, got, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs the DUT just sampled.
    task automatic model_step();
        bit rdy;
        bit nv;
        bit ne;
        rdy = m_ready();
        nv  = 1'b0;
        ne  = 1'b0;
        if (!RST_N) begin
            act   = 1'b0;
            e_dat = 8'h00;
            armed = 1'b1;
        end else if (act) begin
            if (ABORT || (mc == done_at)) begin
                act = 1'b0;
            end else if (rdy && S_VALID) begin
                nv     = 1'b1;
                e_dat  = S_DATA;
                n_left = n_left - 1;
                t_hs   = mc;
                idle   = 0;
                if (n_left == 0)
                    done_at = (mc + 1) + GAP + SETUP + (rr ? RCY : 0) + 1;
            end else if (rdy) begin
                idle = idle + 1;
                if (idle == TMO) begin
                    act = 1'b0;
                    ne  = 1'b1;
                end
            end
        end else if (START) begin
            if (LEN == '0) begin
                ne = 1'b1;
            end else begin
                act     = 1'b1;
                t_st    = mc;
                n_left  = int'(LEN);
                rr      = DO_RECFG;
                t_hs    = -1000;
                idle    = 0;
                done_at = -1;
            end
        end
        e_vld = nv;
        e_err = ne;
        mc    = mc + 1;
    endtask

    task automatic compare();
        chk("s_ready",   S_READY,   m_ready());
        chk("cfg_en",    CFG_EN,    m_en());
        chk("cfg_recfg", CFG_RECFG, m_recfg());
        chk("cfg_valid", CFG_VALID, e_vld);
        chk("cfg_data",  CFG_DATA,  e_dat);
        chk("busy",      BUSY,      act);
        chk("done",      DONE,      m_done());
        chk("err",       ERR,       e_err);
    endtask

    task automatic cyc();
        bit hs_now;
        hs_now = (S_READY === 1'b1) && (S_VALID === 1'b1);
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        if (armed) compare();
        if (hs_now && (src_q.size() > 0)) void'(src_q.pop_front());
        S_DATA = (src_q.size() > 0) ? src_q[0] : 8'($urandom);
        if (auto_vld) S_VALID = (src_q.size() > 0);
    endtask

    task automatic rec(input int k);
        r_en[k]   = CFG_EN;
        r_vld[k]  = CFG_VALID;
        r_rc[k]   = CFG_RECFG;
        r_done[k] = DONE;
        r_err[k]  = ERR;
        r_busy[k] = BUSY;
        r_dat[k]  = CFG_DATA;
    endtask

    // Pulse START and record n cycles; k=1 is the first cycle after the START edge.
    task automatic go(input int len, input bit rc, input int n);
        LEN      = LW'(len);
        DO_RECFG = rc;
        START    = 1'b1;
        cyc();
        START    = 1'b0;
        rec(1);
        for (int k = 2; k <= n; k++) begin
            cyc();
            rec(k);
        end
    endtask

    task automatic load_src(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int n);
        src_q.delete();
        if (n > 0) src_q.push_back(a);
        if (n > 1) src_q.push_back(b);
        if (n > 2) src_q.push_back(c);
        S_DATA  = (src_q.size() > 0) ? src_q[0] : 8'h00;
        S_VALID = (src_q.size() > 0);
    endtask

    function automatic int count_of(input int sel, input int n);
        int c;
        c = 0;
        for (int k = 1; k <= n; k++) begin
            case (sel)
                0: c += int'(r_vld[k]);
                1: c += int'(r_done[k]);
                2: c += int'(r_err[k]);
                default: c += int'(r_rc[k]);
            endcase
        end
        return c;
    endfunction

    initial begin
        RST_N = 1'b0; START = 1'b0; LEN = '0; DO_RECFG = 1'b0; ABORT = 1'b0;
        S_VALID = 1'b0; S_DATA = 8'h00;
        repeat (3) cyc();
        chk("reset_busy", BUSY, 1'b0);
        chk("reset_data", CFG_DATA, 8'h00);
        RST_N = 1'b1;
        repeat (2) cyc();

        // Nominal three-byte load, no RECFG.
        auto_vld = 1'b1;
        load_src(8'hA5, 8'h5A, 8'hFF, 3);
        go(3, 1'b0, 20);
        chk("nom_en_rise",   r_en[1], 1'b1);
        chk("nom_strobe1",   {r_vld[6], r_dat[6]},   {1'b1, 8'hA5});
        chk("nom_strobe2",   {r_vld[8], r_dat[8]},   {1'b1, 8'h5A});
        chk("nom_strobe3",   {r_vld[10], r_dat[10]}, {1'b1, 8'hFF});
        chk("nom_n_strobes", count_of(0, 20), 3);
        chk("nom_en_tail",   r_en[15], 1'b1);
        chk("nom_done",      {r_done[16], r_en[16]}, 2'b10);
        chk("nom_idle",      r_busy[17], 1'b0);
        chk("nom_no_recfg",  count_of(3, 20), 0);

        // Single byte with RECFG.
        load_src(8'h3C, 8'h00, 8'h00, 1);
        go(1, 1'b1, 20);
        chk("rc_window",  {r_rc[11], r_rc[12], r_rc[13], r_rc[14]}, 4'b0110);
        chk("rc_en",      {r_en[12], r_en[13]}, 2'b11);
        chk("rc_done",    r_done[14], 1'b1);
        chk("rc_n_done",  count_of(1, 20), 1);

        // Starvation after two of five bytes.
        load_src(8'h01, 8'h02, 8'h00, 2);
        go(5, 1'b0, 30);
        chk("to_en_last",  r_en[24], 1'b1);
        chk("to_err",      {r_err[25], r_en[25], r_busy[25]}, 3'b100);
        chk("to_n_err",    count_of(2, 30), 1);
        chk("to_no_done",  count_of(1, 30), 0);

        // ABORT coinciding with a handshake, then a clean load.
        src_q.delete();
        src_q.push_back(8'h11); src_q.push_back(8'h22);
        src_q.push_back(8'h33); src_q.push_back(8'h44);
        S_DATA = 8'h11; S_VALID = 1'b1;
        go(4, 1'b0, 5);
        chk("ab_ready", S_READY, 1'b1);
        ABORT = 1'b1;
        cyc();
        ABORT = 1'b0;
        chk("ab_after", {CFG_VALID, CFG_EN, BUSY, S_READY}, 4'b0000);
        chk("ab_data_kept", CFG_DATA, 8'h02);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            rec(k);
        end
        chk("ab_quiet", count_of(1, 6) + count_of(2, 6), 0);
        go(2, 1'b0, 16);
        chk("ab_clean1", {r_vld[6], r_dat[6]}, {1'b1, 8'h22});
        chk("ab_clean2", {r_vld[8], r_dat[8]}, {1'b1, 8'h33});
        chk("ab_clean_done", r_done[14], 1'b1);

        // Zero-length START.
        src_q.delete(); S_VALID = 1'b0;
        LEN = '0; START = 1'b1;
        cyc();
        START = 1'b0;
        chk("zl_err", {ERR, BUSY}, 2'b10);
        cyc();
        chk("zl_err_pulse", ERR, 1'b0);

        // START while busy is ignored.
        src_q.delete();
        for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h80 + i));
        S_DATA = 8'h80; S_VALID = 1'b1;
        go(2, 1'b0, 3);
        LEN = LW'(5); START = 1'b1;
        cyc();
        START = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            rec(k);
        end
        chk("busy_start_strobes", count_of(0, 20), 2);
        chk("busy_start_done",    count_of(1, 20), 1);

        // Reset in the middle of RECFG.
        load_src(8'h77, 8'h00, 8'h00, 1);
        go(1, 1'b1, 12);
        chk("rst_in_recfg", CFG_RECFG, 1'b1);
        RST_N = 1'b0;
        cyc();
        RST_N = 1'b1;
        chk("rst_outs", {CFG_EN, CFG_RECFG, CFG_VALID, BUSY, DONE, ERR, S_READY}, 7'b0);
        chk("rst_data", CFG_DATA, 8'h00);

        // Randomized traffic with varying source availability.
        auto_vld = 1'b0;
        src_q.delete();
        for (int blk = 0; blk < 20; blk++) begin
            int pv;
            case (blk % 4)
                0: pv = 100;
                1: pv = 60;
                2: pv = 20;
                default: pv = 0;
            endcase
            for (int i = 0; i < 150; i++) begin
                START    = ($urandom_range(0, 15) == 0);
                LEN      = LW'($urandom_range(0, 5));
                DO_RECFG = $urandom_range(0, 1) == 1;
                ABORT    = ($urandom_range(0, 99) == 0);
                S_VALID  = ($urandom_range(0, 99) < pv);
                RST_N    = ($urandom_range(0, 499) != 0);
                cyc();
            end
        end
        RST_N = 1'b1; START = 1'b0; ABORT = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cfg_ctrl_seq.md
# cfg_ctrl_seq

Sequencer that drives the CC_CFG_CTRL configuration primitive from a byte stream. Takes a start command with a byte count, raises the enable line with a setup window and forwards each accepted byte as a one-cycle VALID strobe with programmable pacing. Optionally pulses RECFG at the end, then reports completion. It sits between a bitstream source (FIFO, SPI loader, host bridge) and the primitive instance at top level.

## Interface
- SETUP_CYC, 4: cycles EN is held before the first byte and after the last byte (>=1).
- GAP_CYC, 1: minimum idle cycles between consecutive VALID strobes (>=0).
- RECFG_CYC, 2: RECFG pulse width in cycles (>=1).
- LEN_W, 24: byte-count width.
- TIMEOUT, 1024: starvation limit in cycles while waiting for source data (>=2).

- CLK  in  1  clock; the primitive's CLK is tied to the same net.
- RST_N  in  1  reset, synchronous, active-low.
- START  in  1  one-cycle command strobe.
- LEN  in  LEN_W  byte count, sampled on START.
- DO_RECFG  in  1  sampled on START; request RECFG at end of load.
- ABORT  in  1  cancel the current load.
- S_DATA  in  8  source byte.
- S_VALID  in  1  source byte valid.
- S_READY  out  1  sequencer accepts byte.
- CFG_DATA  out  8  to primitive DATA.
- CFG_EN  out  1  to primitive EN.
- CFG_RECFG  out  1  to primitive RECFG.
- CFG_VALID  out  1  to primitive VALID.
- BUSY  out  1  high in any state except IDLE.
- DONE  out  1  one-cycle pulse on successful completion.
- ERR  out  1  one-cycle pulse on timeout or zero-length START.

## Operation
- All outputs are registered. Reset value of every output is 0, and the FSM resets to IDLE.
- FSM states: IDLE, SETUP, STREAM, TAIL, RECFG, FIN.
- IDLE:
  - On START with LEN!=0: latch LEN into `remaining` and DO_RECFG into `recfg_req`, then go to SETUP.
  - On START with LEN==0: pulse ERR and stay in IDLE.
- SETUP: CFG_EN=1 for SETUP_CYC cycles, then go to STREAM.
- STREAM:
  - CFG_EN=1.
  - S_READY = (gap_cnt==0) && (remaining!=0).
  - On handshake (S_VALID && S_READY): CFG_DATA<=S_DATA, CFG_VALID<=1 for exactly the next cycle, gap_cnt<=GAP_CYC, remaining decrements, and the timeout counter clears.
  - When remaining reaches 0 and gap_cnt reaches 0: go to TAIL.
- TAIL: CFG_EN=1 for SETUP_CYC cycles, then go to RECFG if recfg_req, else to FIN.
- RECFG: CFG_EN=1 and CFG_RECFG=1 for RECFG_CYC cycles, then go to FIN.
- FIN: CFG_EN drops, DONE pulses, return to IDLE.
- Timeout: in STREAM, a counter increments every cycle that S_READY=1 and S_VALID=0. On reaching TIMEOUT: pulse ERR, drop CFG_EN, go to IDLE. DONE does not pulse and RECFG is never issued.
- ABORT, in any non-IDLE state: next cycle is IDLE with CFG_EN, CFG_RECFG, CFG_VALID and S_READY all 0. No DONE, no ERR. ABORT wins over a simultaneous handshake; that byte is consumed from the source but is not strobed.
- START while BUSY is ignored. START in the same cycle as an ABORT in IDLE: START wins.
- CFG_DATA holds its last value between strobes. It changes only on handshake and is reset to 0.
- Reset mid-load returns the block to IDLE immediately. The primitive sees EN fall on the following edge.

## Timing
- Handshake at cycle t gives CFG_VALID=1 at t+1. S_READY can next be high at t+1+GAP_CYC. Peak rate is one byte per (1+GAP_CYC) cycles.
- START at t gives CFG_EN=1 at t+1. First possible S_READY is at t+1+SETUP_CYC.
- CFG_DATA is stable on the cycle CFG_VALID is high.
- CFG_EN stays high continuously from SETUP through RECFG, with no glitches between states.
- Completion to DONE: last strobe + GAP_CYC + SETUP_CYC + (recfg_req ? RECFG_CYC : 0) + 1 cycles.
- The counters are sized so that SETUP_CYC, GAP_CYC, RECFG_CYC and TIMEOUT never wrap. `remaining` never underflows: S_READY is gated by remaining!=0.

## Structure
- Package cfg_ctrl_seq_pkg holds:
  - the state enum (IDLE..FIN);
  - default parameter constants;
  - the $clog2-derived counter width helpers.
- One sub-module, cfg_seq_cnt: a loadable down-counter with a zero flag. It is instanced for the shared phase counter (SETUP/TAIL/RECFG), the gap counter and the timeout counter. The FSM stays in the top-level cfg_ctrl_seq.

## Test plan
- Nominal load, defaults, LEN=3, bytes 0xA5, 0x5A, 0xFF with S_VALID always high, DO_RECFG=0:
  - EN rises 1 cycle after START;
  - three VALID strobes 2 cycles apart carry those bytes;
  - EN falls and DONE pulses 4+1 cycles after the last gap;
  - RECFG stays 0.
- Load with DO_RECFG=1, LEN=1: after TAIL, RECFG is high exactly 2 cycles with EN high, then DONE. Total START-to-DONE latency is 1+4+1+1+4+2+1 cycles.
- Back-pressure with GAP_CYC=0, LEN=4, S_VALID toggling every other cycle: each strobe lines up with the preceding handshake, no byte is dropped or duplicated, and S_READY falls once remaining=0.
- Starvation with TIMEOUT=16: after 2 of 5 bytes, S_VALID is held low → ERR pulses on the 16th idle cycle, EN drops, no DONE, BUSY=0.
- ABORT during STREAM coinciding with a handshake: no strobe for that byte, EN=0 the next cycle, no DONE and no ERR. A START issued afterwards runs a clean load.
- Corner commands:
  - START with LEN=0 → ERR pulse, BUSY stays 0.
  - START while BUSY → ignored.
  - RST_N low mid-RECFG → all outputs 0 on the next edge.
